// File: rtl/ws2812_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_pkg
//  Description : Shared state encoding and default timing constants for the
//                WS2812 pixel serializer (12 MHz clock, 1.25 us per bit).
//  Revision    : 1.0  initial release
// ============================================================================
package ws2812_pkg;

    localparam int CYCLES_PER_BIT = 15;
    localparam int T0H_CYCLES     = 4;
    localparam int T1H_CYCLES     = 9;
    localparam int BITS_PER_PIXEL = 24;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOADED = 2'd1,
        ST_SEND   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/ws2812_bit_timer.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_bit_timer
//  Description : Cycle counter for one WS2812 bit period plus the high-time
//                compare that shapes the pulse.
//  Ports       : clk, reset      - clock / synchronous active-high reset
//                clear           - force the counter back to cycle 0
//                run             - advance one cycle (wraps at bit end)
//                bit_is_one      - selects T1H (1) or T0H (0) high time
//                bit_end         - counter is at its last cycle of the bit
//                level           - line level for the current counter value
//  Revision    : 1.0  initial release
// ============================================================================
module ws2812_bit_timer #(
    parameter int CYCLES_PER_BIT = ws2812_pkg::CYCLES_PER_BIT,
    parameter int T0H_CYCLES     = ws2812_pkg::T0H_CYCLES,
    parameter int T1H_CYCLES     = ws2812_pkg::T1H_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic run,
    input  logic bit_is_one,
    output logic bit_end,
    output logic level
);
    import ws2812_pkg::*;

    localparam int              c_cnt_w = $clog2(CYCLES_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CYCLES_PER_BIT - 1);
    // One extra bit so a high time equal to a power of two still compares.
    localparam logic [c_cnt_w:0]   c_t0h  = (c_cnt_w + 1)'(T0H_CYCLES);
    localparam logic [c_cnt_w:0]   c_t1h  = (c_cnt_w + 1)'(T1H_CYCLES);

    logic [c_cnt_w-1:0] r_cyc;
    logic [c_cnt_w:0]   w_thr;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cyc <= '0;
        end else if (clear) begin
            r_cyc <= '0;
        end else if (run) begin
            r_cyc <= bit_end ? '0 : r_cyc + c_cnt_w'(1);
        end
    end

    always_comb begin
        w_thr   = bit_is_one ? c_t1h : c_t0h;
        bit_end = (r_cyc == c_last);
        level   = ({1'b0, r_cyc} < w_thr);
    end

endmodule
`default_nettype wire

// File: rtl/ws2812_serializer.sv
`default_nettype none
// ============================================================================
//  Module      : ws2812_serializer
//  Description : Serialises one 24-bit GRB pixel onto a WS2812 data line.
//  Ports       : clk, reset        - clock / synchronous active-high reset
//                load_sreg         - strobe: capture {green, red, blue}
//                transmit_pixel    - level: high while the pixel is sent
//                red, green, blue  - colour channels (valid with load_sreg)
//                dout              - registered serial data line
//                bit_index         - bit counter (0..23)
//                pixel_done        - one-cycle pulse after bit 23
//                overrun           - sticky protocol-violation flag
//  Revision    : 1.0  initial release
// ============================================================================
module ws2812_serializer #(
    parameter int CYCLES_PER_BIT = ws2812_pkg::CYCLES_PER_BIT,
    parameter int T0H_CYCLES     = ws2812_pkg::T0H_CYCLES,
    parameter int T1H_CYCLES     = ws2812_pkg::T1H_CYCLES
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_sreg,
    input  logic       transmit_pixel,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic       dout,
    output logic [4:0] bit_index,
    output logic       pixel_done,
    output logic       overrun
);
    import ws2812_pkg::*;

    localparam logic [4:0] c_last_bit = 5'(BITS_PER_PIXEL - 1);

    state_t                    r_state, w_state_nxt;
    logic [BITS_PER_PIXEL-1:0] r_sreg,  w_sreg_nxt;
    logic [4:0]                r_bit,   w_bit_nxt;
    logic                      r_dout,  w_dout_nxt;
    logic                      r_done,  w_done_nxt;
    logic                      r_ovr,   w_ovr_nxt;
    // Set when a pixel completes; while transmit_pixel stays high after that
    // the controller has overstayed the 24-bit window.
    logic                      r_tail,  w_tail_nxt;
    logic                      w_clear, w_run, w_bit_end, w_level;

    ws2812_bit_timer #(
        .CYCLES_PER_BIT (CYCLES_PER_BIT),
        .T0H_CYCLES     (T0H_CYCLES),
        .T1H_CYCLES     (T1H_CYCLES)
    ) u_bit_timer (
        .clk        (clk),
        .reset      (reset),
        .clear      (w_clear),
        .run        (w_run),
        .bit_is_one (r_sreg[BITS_PER_PIXEL-1]),
        .bit_end    (w_bit_end),
        .level      (w_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_sreg  <= '0;
            r_bit   <= '0;
            r_dout  <= 1'b0;
            r_done  <= 1'b0;
            r_ovr   <= 1'b0;
            r_tail  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sreg  <= w_sreg_nxt;
            r_bit   <= w_bit_nxt;
            r_dout  <= w_dout_nxt;
            r_done  <= w_done_nxt;
            r_ovr   <= w_ovr_nxt;
            r_tail  <= w_tail_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_sreg_nxt  = r_sreg;
        w_bit_nxt   = r_bit;
        w_dout_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_ovr_nxt   = r_ovr;
        w_tail_nxt  = r_tail;
        w_clear     = 1'b0;
        w_run       = 1'b0;

        if (load_sreg) begin
            w_sreg_nxt = {green, red, blue};
            w_bit_nxt  = '0;
            w_clear    = 1'b1;
            w_tail_nxt = 1'b0;
            if (r_state == ST_SEND) begin
                // Reload mid-pixel: abandon it and wait for a fresh transmit.
                w_ovr_nxt   = 1'b1;
                w_state_nxt = ST_LOADED;
            end else if (transmit_pixel) begin
                w_state_nxt = ST_SEND;
            end else begin
                w_state_nxt = ST_LOADED;
            end
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (transmit_pixel && r_tail) begin
                        w_ovr_nxt = 1'b1;
                    end
                    if (!transmit_pixel) begin
                        w_tail_nxt = 1'b0;
                    end
                end
                ST_LOADED, ST_SEND: begin
                    // The first transmit cycle seen in LOADED is already
                    // cycle 0 of bit 0, so a 24-bit window fits exactly.
                    if (transmit_pixel) begin
                        w_run       = 1'b1;
                        w_dout_nxt  = w_level;
                        w_state_nxt = ST_SEND;
                        if (w_bit_end) begin
                            w_sreg_nxt = {r_sreg[BITS_PER_PIXEL-2:0], 1'b0};
                            if (r_bit == c_last_bit) begin
                                w_done_nxt  = 1'b1;
                                w_tail_nxt  = 1'b1;
                                w_state_nxt = ST_IDLE;
                            end else begin
                                w_bit_nxt = r_bit + 5'd1;
                            end
                        end
                    end else if (r_state == ST_SEND) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    assign dout       = r_dout;
    assign bit_index  = r_bit;
    assign pixel_done = r_done;
    assign overrun    = r_ovr;

endmodule
`default_nettype wire

// File: doc/ws2812_serializer.md
WS2812_SERIALIZER -- requirements
Module: ws2812_serializer

Interface
REQ-001 SHALL have parameter CYCLES_PER_BIT, default 15, giving clk cycles per WS2812 bit (1.25 us at 12 MHz).
REQ-002 SHALL have parameter T0H_CYCLES, default 4, giving the high time of a '0' bit in cycles.
REQ-003 SHALL have parameter T1H_CYCLES, default 9, giving the high time of a '1' bit in cycles.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 load_sreg  input  1  one-cycle strobe: capture pixel colour into the shift register.
REQ-007 transmit_pixel  input  1  level: high for exactly 24 x CYCLES_PER_BIT cycles while the pixel is sent.
REQ-008 red, green, blue  input  8 each  colour channels of the current pixel, valid while load_sreg is high.
REQ-009 dout  output  1  registered serial line to the LED matrix data pin.
REQ-010 bit_index  output  5  index (0..23) of the bit currently on dout.
REQ-011 pixel_done  output  1  one-cycle pulse after the 24th bit completes.
REQ-012 overrun  output  1  sticky flag: transmit_pixel held beyond 24 bits, or load_sreg arrived during SEND.

Function
REQ-013 SHALL implement states IDLE, LOADED, SEND.
REQ-014 IDLE -> LOADED on load_sreg; sreg <= {green, red, blue} (GRB order, MSB first); bit counter and cycle counter <= 0.
REQ-015 LOADED -> SEND on first cycle with transmit_pixel = 1; LOADED holds otherwise, dout = 0.
REQ-016 In SEND, cycle counter SHALL count 0..CYCLES_PER_BIT-1; at terminal count it wraps to 0, sreg shifts left by 1 and bit_index increments.
REQ-017 dout SHALL be 1 when cycle counter < (sreg[23] ? T1H_CYCLES : T0H_CYCLES), else 0; dout registered, 1 cycle latency after the counter value.
REQ-018 On terminal count of bit 23: pixel_done = 1 for one cycle, state -> IDLE, dout low thereafter.
REQ-019 transmit_pixel still high after bit 23 SHALL set overrun; dout stays 0.
REQ-020 transmit_pixel falling during SEND before bit 23 completes SHALL abort: state -> IDLE, dout = 0 next cycle, no pixel_done.
REQ-021 load_sreg during SEND SHALL set overrun, abort current pixel and reload sreg (state -> LOADED).
REQ-022 load_sreg and transmit_pixel high in the same cycle from IDLE SHALL load and go directly to SEND with cycle counter 0.
REQ-023 Counter widths SHALL be $clog2(CYCLES_PER_BIT) and 5 bits; no wrap beyond 23.
REQ-024 Upstream controller updates strobes on falling edge; this block samples on rising edge (half-cycle setup, no synchronizer).

Reset
REQ-025 reset SHALL force state IDLE, sreg = 0, counters = 0, dout = 0, bit_index = 0, pixel_done = 0, overrun = 0, taking priority over all inputs including mid-pixel.
REQ-026 overrun SHALL clear only on reset.

Structure
REQ-027 Package ws2812_pkg SHALL hold the state enum and default constants CYCLES_PER_BIT, T0H_CYCLES, T1H_CYCLES, BITS_PER_PIXEL = 24.
REQ-028 Sub-module ws2812_bit_timer SHALL hold the cycle counter and high-time compare, emitting bit_end and level.

Verification
REQ-029 Reset, load G=0xFF R=0x00 B=0xAA, transmit_pixel for 360 cycles -> bits 0-7 high 9 cycles, bits 8-15 high 4 cycles, bits 16-23 alternate 9/4; pixel_done at cycle 360.
REQ-030 Colour all zeros -> 24 pulses of exactly 4 high / 11 low; total 360 cycles; overrun = 0.
REQ-031 Drop transmit_pixel after 100 cycles -> dout low from cycle 101, no pixel_done, state IDLE.
REQ-032 Hold transmit_pixel 370 cycles -> overrun = 1 from cycle 361, dout = 0 cycles 361-370.
REQ-033 Assert reset at bit 12 mid-high -> dout = 0, bit_index = 0 next cycle; subsequent load sends cleanly.
REQ-034 load_sreg with transmit_pixel same cycle, GRB = 0x800000 -> first bit high 9 cycles starting one cycle later.
